// File: rtl/vrf_pkg.sv
// Shared types and sizes for the vector register file and its scoreboard.
// Lane i of a vector occupies bits [i*ELEM_W +: ELEM_W].
package vrf_pkg;

    localparam int LANES    = 4;
    localparam int ELEM_W   = 32;
    localparam int REG_QTY  = 8;
    localparam int SEL_BITS = 3;
    localparam int VREG_W   = LANES * ELEM_W;

    typedef logic [ELEM_W-1:0]   elem_t;
    typedef elem_t [LANES-1:0]   vreg_t;
    typedef logic [SEL_BITS-1:0] rsel_t;
    typedef logic [LANES-1:0]    lmask_t;
    typedef logic [REG_QTY-1:0]  busy_t;

    function automatic vreg_t merge_lanes(
        input vreg_t  old_v,
        input vreg_t  new_v,
        input lmask_t mask
    );
        vreg_t res;
        for (int l = 0; l < LANES; l++) begin
            res[l] = mask[l] ? new_v[l] : old_v[l];
        end
        return res;
    endfunction

endpackage

// File: rtl/vector_reg_file_sb_scoreboard.sv
// Busy-bit scoreboard: RAW/WAW detection for the issue stage.
// A same-cycle retire hides a busy bit; a same-cycle issue overrides the retire.
module reg_scoreboard
    import vrf_pkg::*;
#(
    parameter bit ZERO_REG = 1'b0
) (
    input  logic  clk,
    input  logic  reset,
    input  rsel_t rSel1,
    input  rsel_t rSel2,
    input  logic  wrEn,
    input  rsel_t regToWrite,
    input  logic  issueEn,
    input  rsel_t issueDest,
    input  logic  issueUseSrc2,
    output logic  hazard,
    output busy_t busyVec
);

    busy_t r_busy;
    busy_t w_retire;
    busy_t w_live;
    busy_t w_set;
    busy_t w_next;
    logic  w_raw1;
    logic  w_raw2;
    logic  w_waw;
    logic  w_accept;

    always_comb begin
        w_retire = '0;
        if (wrEn) begin
            w_retire[regToWrite] = 1'b1;
        end
    end

    assign w_live = r_busy & ~w_retire;

    assign w_raw1 = w_live[rSel1];
    assign w_raw2 = issueUseSrc2 & w_live[rSel2];
    assign w_waw  = w_live[issueDest];
    assign hazard = issueEn & (w_raw1 | w_raw2 | w_waw);

    assign w_accept = issueEn & ~hazard
                    & ~(ZERO_REG && (issueDest == '0));

    always_comb begin
        w_set = '0;
        if (w_accept) begin
            w_set[issueDest] = 1'b1;
        end
    end

    // Set after clear: the retire belongs to the older instruction.
    always_comb begin
        w_next = (r_busy & ~w_retire) | w_set;
        if (ZERO_REG) begin
            w_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_next;
        end
    end

    assign busyVec = r_busy;

endmodule

// File: rtl/vector_reg_file_sb.sv
// Multi-lane vector register file with lane-masked writeback, same-cycle
// bypass on both read ports, and an issue scoreboard.
module vector_reg_file_sb
    import vrf_pkg::*;
#(
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEL_BITS-1:0] rSel1,
    input  logic [SEL_BITS-1:0] rSel2,
    output logic [VREG_W-1:0] reg1Out,
    output logic [VREG_W-1:0] reg2Out,
    input  logic              wrEn,
    input  logic [SEL_BITS-1:0] regToWrite,
    input  logic [LANES-1:0]  laneMask,
    input  logic [VREG_W-1:0] dataIn,
    input  logic              issueEn,
    input  logic [SEL_BITS-1:0] issueDest,
    input  logic              issueUseSrc2,
    output logic              hazard,
    output logic [REG_QTY-1:0] busyVec
);

    vreg_t r_mem [REG_QTY];
    vreg_t w_din;
    vreg_t w_rd1;
    vreg_t w_rd2;
    logic  w_wr_ok;

    assign w_din   = dataIn;
    assign w_wr_ok = wrEn & ~(ZERO_REG && (regToWrite == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < REG_QTY; r++) begin
                r_mem[r] <= '0;
            end
        end else begin
            for (int r = 0; r < REG_QTY; r++) begin
                for (int l = 0; l < LANES; l++) begin
                    if (w_wr_ok && (regToWrite == rsel_t'(r)) && laneMask[l]) begin
                        r_mem[r][l] <= w_din[l];
                    end
                end
            end
        end
    end

    always_comb begin
        w_rd1 = r_mem[rSel1];
        if (w_wr_ok && (regToWrite == rSel1)) begin
            w_rd1 = merge_lanes(w_rd1, w_din, laneMask);
        end
        if (ZERO_REG && (rSel1 == '0)) begin
            w_rd1 = '0;
        end
    end

    always_comb begin
        w_rd2 = r_mem[rSel2];
        if (w_wr_ok && (regToWrite == rSel2)) begin
            w_rd2 = merge_lanes(w_rd2, w_din, laneMask);
        end
        if (ZERO_REG && (rSel2 == '0)) begin
            w_rd2 = '0;
        end
    end

    assign reg1Out = w_rd1;
    assign reg2Out = w_rd2;

    reg_scoreboard #(
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk          (clk),
        .reset        (reset),
        .rSel1        (rSel1),
        .rSel2        (rSel2),
        .wrEn         (wrEn),
        .regToWrite   (regToWrite),
        .issueEn      (issueEn),
        .issueDest    (issueDest),
        .issueUseSrc2 (issueUseSrc2),
        .hazard       (hazard),
        .busyVec      (busyVec)
    );

endmodule
